// File: rtl/adder_result_accum_if.sv
// Handshake bundle between the carry-select adder stage, the frame accumulator
// and the statistics/readback logic.
interface adder_result_accum_if #(
   parameter int WIDTH = 64,
   parameter int OVF_W = 8,
   parameter int CNT_W = 16
);
   logic                     clr;
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         in_sum;
   logic                     in_cout;
   logic                     in_last;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH+OVF_W-1:0]   out_sum;
   logic [CNT_W-1:0]         out_count;
   logic                     out_sat;

   modport master (
      output clr, in_valid, in_sum, in_cout, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_sat
   );

   modport slave (
      input  clr, in_valid, in_sum, in_cout, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_sat
   );
endinterface

// File: rtl/adder_result_accum.sv
// Accumulates a frame of {cout, sum} adder results into a saturating total and
// holds the frame total, term count and saturation flag until taken downstream.
//
// state | meaning
// ACC   | accepting terms of the current frame
// HOLD  | frame result presented, waiting for out_ready
module adder_result_accum #(
   parameter int WIDTH = 64,
   parameter int OVF_W = 8,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   adder_result_accum_if.slave bus
);
   localparam int AW = WIDTH + OVF_W;

   typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic             first_q, first_d;
   logic             out_valid_q, out_valid_d;
   logic [AW-1:0]    out_sum_q, out_sum_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic             out_sat_q, out_sat_d;

   logic             in_ready;
   logic             take;
   logic [AW-1:0]    term;
   logic [AW:0]      sum_ext;
   logic [AW-1:0]    acc_new;
   logic [CNT_W-1:0] cnt_new;
   logic             sat_new;

   assign in_ready = (state_q == ACC) && !bus.clr && !rst;
   assign take     = bus.in_valid && in_ready;
   assign term     = AW'({bus.in_cout, bus.in_sum});
   assign sum_ext  = {1'b0, acc_q} + {1'b0, term};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         first_q     <= 1'b1;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         first_q     <= first_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_count_q <= out_count_d;
         out_sat_q   <= out_sat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACC:     if (take && bus.in_last) state_d = HOLD;
         HOLD:    if (bus.out_ready) state_d = ACC;
         default: state_d = ACC;
      endcase
   end

   // Updated frame values if the current term is accepted; sat is sticky.
   always_comb begin
      acc_new = acc_q;
      cnt_new = cnt_q;
      sat_new = sat_q;
      if (first_q) begin
         acc_new = term;
         cnt_new = CNT_W'(1);
         sat_new = 1'b0;
      end else begin
         cnt_new = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
         if (sat_q || sum_ext[AW]) begin
            acc_new = '1;
            sat_new = 1'b1;
         end else begin
            acc_new = sum_ext[AW-1:0];
         end
      end
   end

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      first_d     = first_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_count_d = out_count_q;
      out_sat_d   = out_sat_q;
      case (state_q)
         ACC: begin
            if (bus.clr) begin
               acc_d   = '0;
               cnt_d   = '0;
               sat_d   = 1'b0;
               first_d = 1'b1;
            end else if (take) begin
               acc_d   = acc_new;
               cnt_d   = cnt_new;
               sat_d   = sat_new;
               first_d = 1'b0;
               if (bus.in_last) begin
                  out_valid_d = 1'b1;
                  out_sum_d   = acc_new;
                  out_count_d = cnt_new;
                  out_sat_d   = sat_new;
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               acc_d       = '0;
               cnt_d       = '0;
               sat_d       = 1'b0;
               first_d     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_count = out_count_q;
   assign bus.out_sat   = out_sat_q;
endmodule
